// File: rtl/dec_onehot_scan.sv
// dec_onehot_scan: registered N-to-2**N one-hot decoder with DIRECT and prescaled SCAN modes
module dec_onehot_scan #(
    parameter int SEL_W = 2,
    parameter int DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel_in,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);
    localparam int N  = 2**SEL_W;
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
    localparam logic [SEL_W-1:0] IMAX = SEL_W'(N - 1);
    localparam logic [N-1:0]     ONE  = N'(1);

    logic [N-1:0]     y_q, y_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             loaded_q, loaded_d;
    logic             mode_q, mode_d;

    // Next-state: blank when disabled, load has priority, SCAN ticks at prescaler terminal count
    always_comb begin
        idx_d    = idx_q;
        pre_d    = pre_q;
        loaded_d = loaded_q;
        mode_d   = mode;
        y_d      = '0;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        if (en) begin
            if (!mode) begin
                pre_d = '0;
                if (load) begin
                    idx_d    = sel_in;
                    loaded_d = 1'b1;
                end
                valid_d = loaded_d;
                y_d     = loaded_d ? ONE << idx_d : '0;
            end else begin
                if (load) begin
                    idx_d    = sel_in;
                    pre_d    = '0;
                    loaded_d = 1'b1;
                end else if (mode != mode_q) begin
                    pre_d = '0;
                end else if (pre_q == PMAX) begin
                    pre_d  = '0;
                    idx_d  = idx_q + 1'b1;
                    wrap_d = idx_q == IMAX;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                valid_d = 1'b1;
                y_d     = ONE << idx_d;
            end
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            idx_q    <= '0;
            pre_q    <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            loaded_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            y_q      <= y_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            loaded_q <= loaded_d;
            mode_q   <= mode_d;
        end
    end

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;
endmodule

// File: tb/tb_dec_onehot_scan.sv
// tb_dec_onehot_scan: three configurations driven in lockstep against an integer reference model
module tb_dec_onehot_scan;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, load = 1'b0;
    logic [2:0] sel = '0;
    logic [3:0] y0;
    logic [7:0] y1, y2;
    logic [1:0] idx0;
    logic [2:0] idx1, idx2;
    logic v0, v1, v2, w0, w1, w2;
    int nchk = 0, nfail = 0;

    int sw [3] = '{2, 3, 3};
    int dv [3] = '{4, 4, 1};
    int m_idx [3], m_cnt [3], m_y [3];
    bit m_ld [3], m_v [3], m_w [3];
    bit m_prev;

    always #5 clk = ~clk;

    dec_onehot_scan #(.SEL_W(2), .DIV(4)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel_in(sel[1:0]), .y(y0), .idx(idx0), .valid(v0), .wrap(w0));
    dec_onehot_scan #(.SEL_W(3), .DIV(4)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel_in(sel), .y(y1), .idx(idx1), .valid(v1), .wrap(w1));
    dec_onehot_scan #(.SEL_W(3), .DIV(1)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel_in(sel), .y(y2), .idx(idx2), .valid(v2), .wrap(w2));

    always @(negedge clk) begin
        nchk++;
        if (!($onehot0(y0) && $onehot0(y1) && $onehot0(y2))) begin
            nfail++;
            $display("FAIL onehot0 y0=%b y1=%b y2=%b required zero or one bit set", y0, y1, y2);
        end
    end

    function automatic logic [39:0] obs(int k);
        case (k)
            0: return {32'(y0), 6'(idx0), v0, w0};
            1: return {32'(y1), 6'(idx1), v1, w1};
            default: return {32'(y2), 6'(idx2), v2, w2};
        endcase
    endfunction

    function automatic logic [39:0] expv(int k);
        return {32'(m_y[k]), 6'(m_idx[k]), m_v[k], m_w[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_y[k] = 0; m_ld[k] = 0; m_v[k] = 0; m_w[k] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n = 1 << sw[k];
            m_w[k] = 0;
            if (!en) begin
                m_y[k] = 0; m_v[k] = 0;
            end else if (!mode) begin
                m_cnt[k] = 0;
                if (load) begin m_idx[k] = int'(sel) % n; m_ld[k] = 1; end
                m_v[k] = m_ld[k];
                m_y[k] = m_ld[k] ? 1 << m_idx[k] : 0;
            end else begin
                if (load) begin
                    m_idx[k] = int'(sel) % n; m_cnt[k] = 0; m_ld[k] = 1;
                end else if (mode != m_prev) begin
                    m_cnt[k] = 0;
                end else if (m_cnt[k] == dv[k] - 1) begin
                    m_cnt[k] = 0;
                    m_w[k] = m_idx[k] == n - 1;
                    m_idx[k] = (m_idx[k] + 1) % n;
                end else begin
                    m_cnt[k]++;
                end
                m_v[k] = 1;
                m_y[k] = 1 << m_idx[k];
            end
        end
        m_prev = mode;
    endtask

    task automatic step(input logic e, input logic m, input logic l, input logic [2:0] s);
        en = e; mode = m; load = l; sel = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (obs(k) !== 40'h0) begin
                nfail++;
                $display("FAIL reset[%0d] got %h required 0", k, obs(k));
            end
        end
        do_reset();
    endtask

    task automatic test_direct_load();
        do_reset();
        step(1, 0, 1, 3'd2);
        nchk++;
        if ({y0, idx0, v0, y1} !== {4'b0100, 2'd2, 1'b1, 8'b0000_0100}) begin
            nfail++;
            $display("FAIL direct_load y0=%b idx0=%0d v0=%b y1=%b required 0100 2 1 00000100", y0, idx0, v0, y1);
        end
        for (int c = 0; c < 4; c++) begin
            step(1, 0, 0, 3'($urandom));
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL direct_hold[%0d] got %h required %h", k, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_direct_noload();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1, 0, 0, 3'($urandom));
            nchk++;
            if ({y0, v0, y1, v1, y2, v2} !== '0) begin
                nfail++;
                $display("FAIL direct_noload y0=%b v0=%b y1=%b v1=%b required all zero", y0, v0, y1, v1);
            end
        end
    endtask

    task automatic test_scan();
        int wraps;
        do_reset();
        wraps = 0;
        for (int c = 0; c < 40; c++) begin
            step(1, 1, 0, 3'd0);
            wraps += int'(w0);
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL scan[%0d] cyc %0d got %h required %h", k, c, obs(k), expv(k));
                end
            end
        end
        nchk++;
        if (wraps != 2) begin
            nfail++;
            $display("FAIL scan_wrap_count got %0d required 2", wraps);
        end
    endtask

    task automatic test_load_tick();
        for (int c = 0; c < 8 && m_cnt[0] != 3; c++) step(1, 1, 0, 3'd0);
        step(1, 1, 1, 3'd3);
        nchk++;
        if ({y0, idx0, w0} !== {4'b1000, 2'd3, 1'b0}) begin
            nfail++;
            $display("FAIL load_tick y0=%b idx0=%0d w0=%b required 1000 3 0", y0, idx0, w0);
        end
        for (int c = 0; c < 9; c++) begin
            step(1, 1, 0, 3'd0);
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL load_tick_after[%0d] cyc %0d got %h required %h", k, c, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_enable();
        for (int c = 0; c < 20 && !(m_idx[0] == 1 && m_cnt[0] == 1); c++) step(1, 1, 0, 3'd0);
        for (int c = 0; c < 5; c++) begin
            step(0, 1, c == 2, 3'd6);
            nchk++;
            if ({y0, v0, w0, y1, v1, y2, v2} !== '0 || idx0 !== 2'd1) begin
                nfail++;
                $display("FAIL enable_off y0=%b v0=%b idx0=%0d y1=%b required 0 0 1 0", y0, v0, idx0, y1);
            end
        end
        step(1, 1, 0, 3'd0);
        nchk++;
        if ({y0, v0} !== {4'b0010, 1'b1}) begin
            nfail++;
            $display("FAIL enable_resume y0=%b v0=%b required 0010 1", y0, v0);
        end
        for (int c = 0; c < 8; c++) begin
            step(1, 1, 0, 3'd0);
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL enable_after[%0d] cyc %0d got %h required %h", k, c, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 7; c++) step(1, 1, 0, 3'd0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            nchk++;
            if (obs(k) !== 40'h0) begin
                nfail++;
                $display("FAIL async_reset[%0d] got %h required 0", k, obs(k));
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(1, 1, 0, 3'd0);
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL async_restart[%0d] cyc %0d got %h required %h", k, c, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_random();
        logic m;
        do_reset();
        m = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) m = ~m;
            step($urandom_range(0, 9) != 0, m, $urandom_range(0, 9) == 0, 3'($urandom));
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL random[%0d] cyc %0d got %h required %h", k, c, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct_load();
        test_direct_noload();
        test_scan();
        test_load_tick();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
